// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the immediate of each instruction
// and queues {imm, type, illegal, inst} in a 2-entry skid FIFO for the decode stage.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_inst_code,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_imm_out,
    output logic [2:0]       o_imm_type,
    output logic             o_illegal,
    output logic [31:0]      o_inst_out,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_CSRZ  = 3'd7
    } immType_e;

    localparam bit IS64 = (XLEN == 64);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [63:0] w_immI;
    logic [63:0] w_immS;
    logic [63:0] w_immB;
    logic [63:0] w_immJ;
    logic [63:0] w_immU;
    logic [63:0] w_immShamt;
    logic [63:0] w_immShamtW;
    logic [63:0] w_immCsrz;
    logic [63:0] w_decImm64;
    logic [XLEN-1:0] w_decImm;
    immType_e    w_decType;
    logic        w_decIllegal;
    logic        w_isShift;

    // Every candidate is built 64 bits wide and truncated at the end, so RV32 and RV64 share one decoder.
    assign w_opcode    = i_inst_code[6:0];
    assign w_funct3    = i_inst_code[14:12];
    assign w_isShift   = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    assign w_immI      = {{52{i_inst_code[31]}}, i_inst_code[31:20]};
    assign w_immS      = {{52{i_inst_code[31]}}, i_inst_code[31:25], i_inst_code[11:7]};
    assign w_immB      = {{51{i_inst_code[31]}}, i_inst_code[31], i_inst_code[7],
                          i_inst_code[30:25], i_inst_code[11:8], 1'b0};
    assign w_immJ      = {{43{i_inst_code[31]}}, i_inst_code[31], i_inst_code[19:12],
                          i_inst_code[20], i_inst_code[30:21], 1'b0};
    assign w_immU      = {{32{i_inst_code[31]}}, i_inst_code[31:12], 12'b0};
    assign w_immShamt  = IS64 ? {58'b0, i_inst_code[25:20]} : {59'b0, i_inst_code[24:20]};
    assign w_immShamtW = {59'b0, i_inst_code[24:20]};
    assign w_immCsrz   = {59'b0, i_inst_code[19:15]};

    always_comb begin
        w_decImm64   = '0;
        w_decType    = IMM_NONE;
        w_decIllegal = 1'b0;
        case (w_opcode)
            7'b0000011, 7'b1100111, 7'b0001111: begin
                w_decImm64 = w_immI;
                w_decType  = IMM_I;
            end
            7'b0010011: begin
                if (w_isShift) begin
                    w_decImm64 = w_immShamt;
                    w_decType  = IMM_SHAMT;
                end else begin
                    w_decImm64 = w_immI;
                    w_decType  = IMM_I;
                end
            end
            7'b0011011: begin
                if (!IS64) begin
                    w_decIllegal = 1'b1;
                end else if (w_isShift) begin
                    w_decImm64 = w_immShamtW;
                    w_decType  = IMM_SHAMT;
                end else begin
                    w_decImm64 = w_immI;
                    w_decType  = IMM_I;
                end
            end
            7'b0100011: begin
                w_decImm64 = w_immS;
                w_decType  = IMM_S;
            end
            7'b1100011: begin
                w_decImm64 = w_immB;
                w_decType  = IMM_B;
            end
            7'b1101111: begin
                w_decImm64 = w_immJ;
                w_decType  = IMM_J;
            end
            7'b0110111, 7'b0010111: begin
                w_decImm64 = w_immU;
                w_decType  = IMM_U;
            end
            7'b1110011: begin
                if (w_funct3[2]) begin
                    w_decImm64 = w_immCsrz;
                    w_decType  = IMM_CSRZ;
                end else begin
                    w_decImm64 = w_immI;
                    w_decType  = IMM_I;
                end
            end
            7'b0110011: begin
                w_decType = IMM_NONE;
            end
            7'b0111011: begin
                w_decIllegal = !IS64;
            end
            default: begin
                w_decIllegal = 1'b1;
            end
        endcase
    end

    assign w_decImm = w_decImm64[XLEN-1:0];

    logic [XLEN-1:0] r_memImm  [2];
    immType_e        r_memType [2];
    logic            r_memIll  [2];
    logic [31:0]     r_memInst [2];
    logic            r_head;
    logic            r_tail;
    logic [1:0]      r_count;
    logic [CNT_W-1:0] r_illegalCnt;
    logic            w_push;
    logic            w_pop;

    // Ready comes from the count register only, so a full FIFO never accepts even while draining.
    assign o_in_ready  = (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign w_push      = i_in_valid && o_in_ready && !i_flush;
    assign w_pop       = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2; i++) begin
                r_memImm[i]  <= '0;
                r_memType[i] <= IMM_NONE;
                r_memIll[i]  <= 1'b0;
                r_memInst[i] <= '0;
            end
        end else if (w_push) begin
            r_memImm[r_tail]  <= w_decImm;
            r_memType[r_tail] <= w_decType;
            r_memIll[r_tail]  <= w_decIllegal;
            r_memInst[r_tail] <= i_inst_code;
        end
    end

    // Flush leaves the counter alone; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_illegalCnt <= '0;
        end else if (w_push && w_decIllegal && (r_illegalCnt != {CNT_W{1'b1}})) begin
            r_illegalCnt <= r_illegalCnt + 1'b1;
        end
    end

    // Head fields read as zero while empty, matching the reset values.
    assign o_imm_out     = o_out_valid ? r_memImm[r_head]  : '0;
    assign o_imm_type    = o_out_valid ? r_memType[r_head] : IMM_NONE;
    assign o_illegal     = o_out_valid ? r_memIll[r_head]  : 1'b0;
    assign o_inst_out    = o_out_valid ? r_memInst[r_head] : '0;
    assign o_illegal_cnt = r_illegalCnt;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (RV32, RV64, RV32 with 1-bit counter) share one
// stimulus stream and are checked every cycle against a queue-based reference model.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [31:0] instCode;

    logic        inReadyA, outValidA, illegalA;
    logic [31:0] immA;
    logic [2:0]  typeA;
    logic [31:0] instA;
    logic [15:0] cntA;

    logic        inReadyB, outValidB, illegalB;
    logic [63:0] immB;
    logic [2:0]  typeB;
    logic [31:0] instB;
    logic [15:0] cntB;

    logic        inReadyC, outValidC, illegalC;
    logic [31:0] immC;
    logic [2:0]  typeC;
    logic [31:0] instC;
    logic [0:0]  cntC;

    imm_gen_stage #(.XLEN(32), .CNT_W(16)) dutA (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(inValid),
        .o_in_ready(inReadyA), .i_inst_code(instCode), .o_out_valid(outValidA),
        .i_out_ready(outReady), .o_imm_out(immA), .o_imm_type(typeA),
        .o_illegal(illegalA), .o_inst_out(instA), .o_illegal_cnt(cntA)
    );

    imm_gen_stage #(.XLEN(64), .CNT_W(16)) dutB (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(inValid),
        .o_in_ready(inReadyB), .i_inst_code(instCode), .o_out_valid(outValidB),
        .i_out_ready(outReady), .o_imm_out(immB), .o_imm_type(typeB),
        .o_illegal(illegalB), .o_inst_out(instB), .o_illegal_cnt(cntB)
    );

    imm_gen_stage #(.XLEN(32), .CNT_W(1)) dutC (
        .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_valid(inValid),
        .o_in_ready(inReadyC), .i_inst_code(instCode), .o_out_valid(outValidC),
        .i_out_ready(outReady), .o_imm_out(immC), .o_imm_type(typeC),
        .o_illegal(illegalC), .o_inst_out(instC), .o_illegal_cnt(cntC)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] modelQ[$];
    logic [15:0] mCntA;
    logic [15:0] mCntB;
    logic        mCntC;

    // Immediate rules computed arithmetically from the instruction fields.
    function automatic void refDecode(input logic [31:0] inst, input bit is64,
                                      output logic [63:0] imm, output logic [2:0] typ,
                                      output logic ill);
        int s;
        logic [6:0] op;
        logic [2:0] f3;
        op  = inst[6:0];
        f3  = inst[14:12];
        imm = 64'd0;
        typ = 3'd0;
        ill = 1'b0;
        s   = int'(inst) >>> 20;
        if (op == 7'h03 || op == 7'h67 || op == 7'h0F ||
            ((op == 7'h13 || (op == 7'h1B && is64)) && f3 != 3'd1 && f3 != 3'd5) ||
            (op == 7'h73 && f3 < 3'd4)) begin
            imm = 64'(longint'(s));
            typ = 3'd1;
        end else if (op == 7'h13) begin
            imm = is64 ? 64'((inst >> 20) & 32'd63) : 64'((inst >> 20) & 32'd31);
            typ = 3'd6;
        end else if (op == 7'h1B && is64) begin
            imm = 64'((inst >> 20) & 32'd31);
            typ = 3'd6;
        end else if (op == 7'h23) begin
            s   = int'(inst) >>> 25;
            imm = 64'(longint'(s)) * 64'd32 + 64'(inst[11:7]);
            typ = 3'd2;
        end else if (op == 7'h63) begin
            imm = (inst[31] ? 64'hFFFF_FFFF_FFFF_F000 : 64'd0) + 64'(inst[7]) * 64'd2048 +
                  64'(inst[30:25]) * 64'd32 + 64'(inst[11:8]) * 64'd2;
            typ = 3'd3;
        end else if (op == 7'h6F) begin
            imm = (inst[31] ? 64'hFFFF_FFFF_FFF0_0000 : 64'd0) + 64'(inst[19:12]) * 64'd4096 +
                  64'(inst[20]) * 64'd2048 + 64'(inst[30:21]) * 64'd2;
            typ = 3'd5;
        end else if (op == 7'h37 || op == 7'h17) begin
            s   = int'(inst & 32'hFFFF_F000);
            imm = 64'(longint'(s));
            typ = 3'd4;
        end else if (op == 7'h73) begin
            imm = 64'((inst >> 15) & 32'd31);
            typ = 3'd7;
        end else if (op == 7'h33 || (op == 7'h3B && is64)) begin
            typ = 3'd0;
        end else begin
            ill = 1'b1;
        end
    endfunction

    task automatic compare(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkVariant(input string name, input bit is64, input logic inRdy,
                                input logic outVld, input logic [63:0] imm, input logic [2:0] typ,
                                input logic ill, input logic [31:0] inst,
                                input logic [63:0] cnt, input logic [63:0] expCnt);
        logic [63:0] eImm;
        logic [2:0]  eTyp;
        logic        eIll;
        logic [31:0] eInst;
        eImm  = 64'd0;
        eTyp  = 3'd0;
        eIll  = 1'b0;
        eInst = 32'd0;
        if (modelQ.size() > 0) begin
            refDecode(modelQ[0], is64, eImm, eTyp, eIll);
            eInst = modelQ[0];
        end
        if (!is64) eImm = eImm & 64'h0000_0000_FFFF_FFFF;
        compare({name, ".in_ready"}, 64'(inRdy), 64'(modelQ.size() < 2));
        compare({name, ".out_valid"}, 64'(outVld), 64'(modelQ.size() != 0));
        compare({name, ".imm_out"}, imm, eImm);
        compare({name, ".imm_type"}, 64'(typ), 64'(eTyp));
        compare({name, ".illegal"}, 64'(ill), 64'(eIll));
        compare({name, ".inst_out"}, 64'(inst), 64'(eInst));
        compare({name, ".illegal_cnt"}, cnt, expCnt);
    endtask

    task automatic checkOutput();
        checkVariant("rv32", 1'b0, inReadyA, outValidA, 64'(immA), typeA, illegalA, instA,
                     64'(cntA), 64'(mCntA));
        checkVariant("rv64", 1'b1, inReadyB, outValidB, immB, typeB, illegalB, instB,
                     64'(cntB), 64'(mCntB));
        checkVariant("cnt1", 1'b0, inReadyC, outValidC, 64'(immC), typeC, illegalC, instC,
                     64'(cntC), 64'(mCntC));
    endtask

    // One clock of stimulus: drive at negedge, check the registered state, advance the model.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic ordy,
                                 input logic fl, input logic rst);
        bit          doPush;
        bit          doPop;
        logic [63:0] dImm;
        logic [2:0]  dTyp;
        logic        ill32;
        logic        ill64;
        @(negedge clk);
        reset    = rst;
        flush    = fl;
        inValid  = v;
        instCode = inst;
        outReady = ordy;
        checkOutput();
        if (rst) begin
            modelQ.delete();
            mCntA = 16'd0;
            mCntB = 16'd0;
            mCntC = 1'b0;
        end else if (fl) begin
            modelQ.delete();
        end else begin
            doPush = v && (modelQ.size() < 2);
            doPop  = (modelQ.size() != 0) && ordy;
            refDecode(inst, 1'b0, dImm, dTyp, ill32);
            refDecode(inst, 1'b1, dImm, dTyp, ill64);
            if (doPush && ill32) begin
                if (mCntA != 16'hFFFF) mCntA = mCntA + 16'd1;
                mCntC = 1'b1;
            end
            if (doPush && ill64 && mCntB != 16'hFFFF) mCntB = mCntB + 16'd1;
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(inst);
        end
        @(posedge clk);
    endtask

    function automatic logic [31:0] randInst();
        logic [6:0]  ops [16] = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F,
                                  7'h37, 7'h17, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h00, 7'h2B};
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], ops[$urandom_range(0, 15)]};
    endfunction

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        instCode = 32'd0;
        mCntA    = 16'd0;
        mCntB    = 16'd0;
        mCntC    = 1'b0;
        repeat (2) @(posedge clk);

        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFFF0_0093, 1'b0, 1'b0, 1'b0);
        #1;
        compare("addi.valid", 64'(outValidA), 64'd1);
        compare("addi.imm", 64'(immA), 64'hFFFF_FFFF);
        compare("addi.type", 64'(typeA), 64'd1);
        applyStimulus(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0, 1'b0);
        #1;
        compare("beq.imm", 64'(immA), 64'hFFFF_FFFC);
        compare("beq.type", 64'(typeA), 64'd3);
        applyStimulus(1'b1, 32'h1234_5037, 1'b1, 1'b0, 1'b0);
        #1;
        compare("lui.imm", 64'(immA), 64'h1234_5000);
        compare("lui.type", 64'(typeA), 64'd4);
        applyStimulus(1'b1, 32'h0210_9093, 1'b1, 1'b0, 1'b0);
        #1;
        compare("slli64.imm", immB, 64'd33);
        compare("slli64.type", 64'(typeB), 64'd6);
        applyStimulus(1'b1, 32'h8000_0037, 1'b1, 1'b0, 1'b0);
        #1;
        compare("lui64.imm", immB, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0020_0113, 1'b0, 1'b0, 1'b0);
        #1;
        compare("full.in_ready", 64'(inReadyA), 64'd0);
        applyStimulus(1'b1, 32'h0030_0193, 1'b0, 1'b0, 1'b0);
        #1;
        compare("full.head", 64'(instA), 64'h0010_0093);
        applyStimulus(1'b1, 32'h0030_0193, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0030_0193, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 32'h0000_007F, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_007F, 1'b0, 1'b0, 1'b0);
        #1;
        compare("sat.cnt1", 64'(cntC), 64'd1);
        compare("sat.illegal", 64'(illegalC), 64'd1);
        applyStimulus(1'b1, 32'h0000_007F, 1'b1, 1'b1, 1'b0);
        #1;
        compare("flush.valid", 64'(outValidA), 64'd0);
        compare("flush.cnt", 64'(cntA), 64'd2);
        applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        compare("reset.in_ready", 64'(inReadyA), 64'd1);
        compare("reset.cnt", 64'(cntA), 64'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInst(), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
